hazard_md_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core.
- Generates StallF/StallD/FlushE for the F/D and D/E pipeline registers from Tuse/Tnew register hazards.
- Owns the multi-cycle mult/div busy counter and stalls D while HI/LO is busy.
- Schedules interrupt entry so that an IRQ is only taken on a non-stalled cycle; it then flushes D/E for one cycle.

---
 rtl/hazard_md_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_md_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_md_ctrl.sv
// Purpose: D-stage stall/flush generation, HI/LO busy counter and interrupt entry scheduling.
// Latency: stall/flush are combinational (0 cycles); md_busy/md_done/irq_take change on the next clk edge.
// Backpressure: StallF/StallD hold the front end; an IRQ waits in PEND until a stall-free cycle.
module hazard_md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [1:0] tuse_rs_D,
    input  logic [1:0] tuse_rt_D,
    input  logic       md_D,
    input  logic [4:0] A3_E,
    input  logic [1:0] tnew_E,
    input  logic [4:0] A3_M,
    input  logic [1:0] tnew_M,
    input  logic       md_start_E,
    input  logic       md_type_E,
    input  logic       IRQ,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushE,
    output logic       md_busy,
    output logic       md_done,
    output logic       md_err,
    output logic       irq_take
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        TAKE = 2'd2,
        HOLD = 2'd3
    } irq_state_t;

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    irq_state_t       state;
    irq_state_t       state_nxt;
    logic             stall_rs;
    logic             stall_rt;
    logic             stall_md;
    logic             stall;

    // A source needs a stall when a younger-than-needed producer in E or M targets it;
    // tnew of 0 can never exceed tuse, and $0 is excluded explicitly.
    assign stall_rs = (rs_D != 5'd0) &&
                      (((rs_D == A3_E) && (tuse_rs_D < tnew_E)) ||
                       ((rs_D == A3_M) && (tuse_rs_D < tnew_M)));
    assign stall_rt = (rt_D != 5'd0) &&
                      (((rt_D == A3_E) && (tuse_rt_D < tnew_E)) ||
                       ((rt_D == A3_M) && (tuse_rt_D < tnew_M)));
    // A start in E counts as busy already, so a back-to-back HI/LO access is held.
    assign stall_md = md_D && (md_busy || md_start_E);
    assign stall    = stall_rs | stall_rt | stall_md;

    assign md_busy  = (cnt != '0);

    // Busy counter: loads only when idle; a start while busy is ignored and flagged sticky.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            md_done <= 1'b0;
            md_err  <= 1'b0;
        end else begin
            md_done <= (cnt == CNT_ONE);
            if (cnt != '0) begin
                cnt <= cnt - CNT_ONE;
                if (md_start_E) begin
                    md_err <= 1'b1;
                end
            end else if (md_start_E) begin
                cnt <= md_type_E ? DIV_LD : MULT_LD;
            end
        end
    end

    // IRQ FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // IRQ FSM next state: request latched in PEND, entry deferred past stalls, HOLD waits for IRQ low.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (IRQ)    state_nxt = PEND;
            PEND:    if (!stall) state_nxt = TAKE;
            TAKE:                state_nxt = HOLD;
            HOLD:    if (!IRQ)   state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // Outputs: the entry cycle releases F/D and bubbles D/E regardless of any stall.
    always_comb begin
        StallF   = stall;
        StallD   = stall;
        FlushE   = stall;
        irq_take = 1'b0;
        if (state == TAKE) begin
            StallF   = 1'b0;
            StallD   = 1'b0;
            FlushE   = 1'b1;
            irq_take = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_md_ctrl.sv
// Purpose: scoreboard bench for hazard_md_ctrl; expected output vectors are queued per cycle.
// Latency: each cycle's expectation is pushed 1 time unit after posedge and popped 2 units later.
// Backpressure: none; the queue must be empty at the end.
module tb_hazard_md_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic [1:0] tuse_rs_D;
    logic [1:0] tuse_rt_D;
    logic       md_D;
    logic [4:0] A3_E;
    logic [1:0] tnew_E;
    logic [4:0] A3_M;
    logic [1:0] tnew_M;
    logic       md_start_E;
    logic       md_type_E;
    logic       IRQ;
    logic       StallF;
    logic       StallD;
    logic       FlushE;
    logic       md_busy;
    logic       md_done;
    logic       md_err;
    logic       irq_take;

    // Observed vector: {StallF, StallD, FlushE, md_busy, md_done, md_err, irq_take}
    logic [6:0] obs;
    assign obs = {StallF, StallD, FlushE, md_busy, md_done, md_err, irq_take};

    int n_cmp = 0;
    int n_err = 0;

    string      tag_q[$];
    logic [6:0] exp_q[$];

    hazard_md_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10),
        .CNT_W      (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rs_D      (rs_D),
        .rt_D      (rt_D),
        .tuse_rs_D (tuse_rs_D),
        .tuse_rt_D (tuse_rt_D),
        .md_D      (md_D),
        .A3_E      (A3_E),
        .tnew_E    (tnew_E),
        .A3_M      (A3_M),
        .tnew_M    (tnew_M),
        .md_start_E(md_start_E),
        .md_type_E (md_type_E),
        .IRQ       (IRQ),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushE    (FlushE),
        .md_busy   (md_busy),
        .md_done   (md_done),
        .md_err    (md_err),
        .irq_take  (irq_take)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic clr();
        rs_D       = 5'd0;
        rt_D       = 5'd0;
        tuse_rs_D  = 2'd3;
        tuse_rt_D  = 2'd3;
        md_D       = 1'b0;
        A3_E       = 5'd0;
        tnew_E     = 2'd0;
        A3_M       = 5'd0;
        tnew_M     = 2'd0;
        md_start_E = 1'b0;
        md_type_E  = 1'b0;
        IRQ        = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [6:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    // Scoreboard side: compare every queued expectation mid-cycle.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            while (exp_q.size() > 0) begin
                chk(tag_q.pop_front(), {25'd0, obs}, {25'd0, exp_q.pop_front()});
            end
        end
    end

    // Stimulus side.
    initial begin
        clr();
        reset = 1'b0;
        #2;
        chk("reset_state", {25'd0, obs}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Register hazards
        tick(); clr(); rs_D = 5'd5; tuse_rs_D = 2'd0; A3_E = 5'd5; tnew_E = 2'd2;
        push("load_use", 7'b1110000);
        tick(); clr(); rs_D = 5'd5; tuse_rs_D = 2'd0; A3_E = 5'd5; tnew_E = 2'd0;
        push("load_use_tnew0", 7'b0000000);
        tick(); clr(); rt_D = 5'd0; tuse_rt_D = 2'd0; A3_E = 5'd0; tnew_E = 2'd2;
        push("zero_reg", 7'b0000000);
        tick(); clr(); rt_D = 5'd7; tuse_rt_D = 2'd0; A3_M = 5'd7; tnew_M = 2'd1;
        push("m_stage", 7'b1110000);
        tick(); clr(); rs_D = 5'd9; tuse_rs_D = 2'd1; A3_E = 5'd9; tnew_E = 2'd1;
        push("tuse_eq_tnew", 7'b0000000);

        // Mult: 5 busy cycles, done on the following one
        tick(); clr(); md_start_E = 1'b1; md_type_E = 1'b0;
        push("mult_start", 7'b0000000);
        for (int i = 0; i < 5; i++) begin
            tick(); clr(); md_D = 1'b1;
            push("mult_busy", 7'b1111000);
        end
        tick(); clr(); md_D = 1'b1;
        push("mult_done", 7'b0000100);
        tick(); clr();
        push("mult_idle", 7'b0000000);

        // Div: 10 busy cycles, restart at busy cycle 3 sets err only
        tick(); clr(); md_start_E = 1'b1; md_type_E = 1'b1;
        push("div_start", 7'b0000000);
        for (int i = 1; i <= 10; i++) begin
            tick(); clr();
            if (i == 3) begin
                md_start_E = 1'b1;
                md_type_E  = 1'b0;
            end
            push("div_busy", (i >= 4) ? 7'b0001010 : 7'b0001000);
        end
        tick(); clr();
        push("div_done", 7'b0000110);
        tick(); clr();
        push("err_sticky", 7'b0000010);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("err_reset", {25'd0, obs}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // IRQ under a 2-cycle load-use stall, then take with override
        for (int i = 0; i < 2; i++) begin
            tick(); clr(); IRQ = 1'b1; rs_D = 5'd5; tuse_rs_D = 2'd0; A3_E = 5'd5; tnew_E = 2'd2;
            push("irq_stalled", 7'b1110000);
        end
        tick(); clr(); IRQ = 1'b1;
        push("irq_pend_free", 7'b0000000);
        tick(); clr(); IRQ = 1'b1; rs_D = 5'd5; tuse_rs_D = 2'd0; A3_E = 5'd5; tnew_E = 2'd2;
        push("irq_take_override", 7'b0010001);
        for (int i = 0; i < 3; i++) begin
            tick(); clr(); IRQ = 1'b1;
            push("irq_hold_no_retake", 7'b0000000);
        end
        tick(); clr(); IRQ = 1'b0;
        push("irq_low", 7'b0000000);
        tick(); clr(); IRQ = 1'b1;
        push("irq_rise_again", 7'b0000000);
        tick(); clr(); IRQ = 1'b1;
        push("irq_pend2", 7'b0000000);
        tick(); clr(); IRQ = 1'b1;
        push("irq_retake", 7'b0010001);
        tick(); clr(); IRQ = 1'b0;
        push("irq_hold2", 7'b0000000);

        // IRQ dropped while pending is still taken
        tick(); clr(); IRQ = 1'b1; rt_D = 5'd3; tuse_rt_D = 2'd1; A3_M = 5'd3; tnew_M = 2'd2;
        push("latch_stall1", 7'b1110000);
        tick(); clr(); IRQ = 1'b0; rt_D = 5'd3; tuse_rt_D = 2'd1; A3_M = 5'd3; tnew_M = 2'd2;
        push("latch_stall2", 7'b1110000);
        tick(); clr();
        push("latch_free", 7'b0000000);
        tick(); clr();
        push("latch_take", 7'b0010001);
        tick(); clr();
        push("latch_hold", 7'b0000000);

        // Async reset mid-div (cnt=6) with IRQ pending behind an MD stall
        tick(); clr(); md_start_E = 1'b1; md_type_E = 1'b1;
        push("div2_start", 7'b0000000);
        for (int i = 0; i < 5; i++) begin
            tick(); clr(); md_D = 1'b1; IRQ = 1'b1;
            push("div2_busy_stall", 7'b1111000);
        end
        #3;
        reset = 1'b0;
        #1;
        chk("async_busy", {31'd0, md_busy}, 32'd0);
        clr();
        #1;
        chk("async_outputs", {25'd0, obs}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); clr();
            push("post_reset_quiet", 7'b0000000);
        end

        tick();
        #3;
        chk("sb_drain", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
